layer_mixer: RTL and testbench

LAYER_MIXER -- requirements
Module: layer_mixer

---
 rtl/layer_mixer.sv | 138 +++++++++++++
 tb/tb_layer_mixer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mixer.sv
// layer_mixer: priority compositor for stacked pixel layers with a frame-paced
// brightness fade and a timing delay line matched to the pixel pipeline.
module layer_mixer #(
  parameter int                 NUM_LAYERS  = 8,
  parameter int                 PIXEL_W     = 12,
  parameter int                 LAYER_LAT   = 4,
  parameter logic [PIXEL_W-1:0] BG_COLOR    = '0,
  parameter int                 FADE_FRAMES = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               hsync_in,
  input  logic                               vsync_in,
  input  logic                               blank_in,
  input  logic [NUM_LAYERS*PIXEL_W-1:0]      layer_pixels_in,
  input  logic [NUM_LAYERS-1:0]              layer_enable_in,
  input  logic [1:0]                         fade_cmd_in,
  output logic [PIXEL_W-1:0]                 pixel_out,
  output logic                               hsync_out,
  output logic                               vsync_out,
  output logic                               blank_out,
  output logic [$clog2(NUM_LAYERS+1)-1:0]    top_layer_out,
  output logic                               fade_busy_out
);

  localparam int IDX_W = $clog2(NUM_LAYERS + 1);
  localparam int CH_W  = PIXEL_W / 3;
  localparam int DLY   = LAYER_LAT + 2;
  localparam int DIV_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  typedef enum logic [1:0] {ST_ON, ST_OFF, ST_FADE_IN, ST_FADE_OUT} fade_state_t;

  fade_state_t          state;
  logic [4:0]           level;
  logic [DIV_W-1:0]     div;
  logic                 vsync_q;
  logic                 frame_tick;
  logic [NUM_LAYERS-1:0] shadow_en;
  logic [DLY-1:0]       hs_dly, vs_dly, bl_dly;
  logic [PIXEL_W-1:0]   sel_pix, s1_pix, scaled;
  logic [IDX_W-1:0]     sel_idx, s1_idx;
  logic                 want_in, want_out;

  assign frame_tick = vsync_q & ~vsync_in;
  assign want_in    = (fade_cmd_in == 2'b01);
  assign want_out   = (fade_cmd_in == 2'b10);

  assign hsync_out  = hs_dly[DLY-1];
  assign vsync_out  = vs_dly[DLY-1];
  assign blank_out  = bl_dly[DLY-1];

  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c, input logic [4:0] lvl);
    return CH_W'(({5'b0, c} * {{CH_W{1'b0}}, lvl}) >> 4);
  endfunction

  // Descending scan so the lowest-index opaque, enabled layer is the last writer.
  always_comb begin
    sel_pix = BG_COLOR;
    sel_idx = IDX_W'(NUM_LAYERS);
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (shadow_en[k] && (layer_pixels_in[k*PIXEL_W +: PIXEL_W] != '0)) begin
        sel_pix = layer_pixels_in[k*PIXEL_W +: PIXEL_W];
        sel_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    scaled = '0;
    for (int ch = 0; ch < 3; ch++) begin
      scaled[ch*CH_W +: CH_W] = scale_ch(s1_pix[ch*CH_W +: CH_W], level);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_dly        <= '0;
      vs_dly        <= '0;
      bl_dly        <= '0;
      vsync_q       <= 1'b0;
      shadow_en     <= '1;
      s1_pix        <= '0;
      s1_idx        <= IDX_W'(NUM_LAYERS);
      pixel_out     <= '0;
      top_layer_out <= IDX_W'(NUM_LAYERS);
    end else begin
      hs_dly        <= {hs_dly[DLY-2:0], hsync_in};
      vs_dly        <= {vs_dly[DLY-2:0], vsync_in};
      bl_dly        <= {bl_dly[DLY-2:0], blank_in};
      vsync_q       <= vsync_in;
      if (frame_tick) begin
        shadow_en <= layer_enable_in;
      end
      s1_pix        <= sel_pix;
      s1_idx        <= sel_idx;
      // Tap one short of the end so the blank lines up with the stage-2 register.
      pixel_out     <= bl_dly[DLY-2] ? '0 : scaled;
      top_layer_out <= s1_idx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_ON;
      level         <= 5'd16;
      div           <= '0;
      fade_busy_out <= 1'b0;
    end else if (want_in && (state == ST_OFF || state == ST_FADE_OUT)) begin
      state         <= ST_FADE_IN;
      div           <= '0;
      fade_busy_out <= 1'b1;
    end else if (want_out && (state == ST_ON || state == ST_FADE_IN)) begin
      state         <= ST_FADE_OUT;
      div           <= '0;
      fade_busy_out <= 1'b1;
    end else if (frame_tick && (state == ST_FADE_IN || state == ST_FADE_OUT)) begin
      if (div == DIV_W'(FADE_FRAMES - 1)) begin
        div <= '0;
        if (state == ST_FADE_IN) begin
          level <= level + 5'd1;
          if (level == 5'd15) begin
            state         <= ST_ON;
            fade_busy_out <= 1'b0;
          end
        end else begin
          level <= level - 5'd1;
          if (level == 5'd1) begin
            state         <= ST_OFF;
            fade_busy_out <= 1'b0;
          end
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: table vectors plus fade/reset sequences, checked through
// expected-output queues fed by a cycle model of the mixer.
module tb_layer_mixer;

  localparam int NL  = 8;
  localparam int PW  = 12;
  localparam int LAT = 4;
  localparam int FF  = 2;
  localparam int IW  = 4;
  localparam logic [PW-1:0] BG = 12'h123;
  localparam int S_ON = 0, S_OFF = 1, S_FIN = 2, S_FOUT = 3;
  localparam int NV = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, blank = 1'b0;
  logic [NL*PW-1:0] layers = '0;
  logic [NL-1:0] en = '1;
  logic [1:0] cmd = 2'b00;
  logic [PW-1:0] pix;
  logic hs_o, vs_o, bl_o, busy;
  logic [IW-1:0] top;

  layer_mixer #(
    .NUM_LAYERS(NL), .PIXEL_W(PW), .LAYER_LAT(LAT), .BG_COLOR(BG), .FADE_FRAMES(FF)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .layer_pixels_in(layers), .layer_enable_in(en), .fade_cmd_in(cmd),
    .pixel_out(pix), .hsync_out(hs_o), .vsync_out(vs_o), .blank_out(bl_o),
    .top_layer_out(top), .fade_busy_out(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [PW-1:0] pix; logic [IW-1:0] idx; } pix_exp_t;
  typedef struct { int due; logic h; logic v; logic b; } sync_exp_t;
  typedef struct { logic [NL*PW-1:0] layers; logic [PW-1:0] pix; logic [IW-1:0] idx; } vec_t;

  pix_exp_t  pix_q[$];
  sync_exp_t sync_q[$];
  logic      blank_hist[$];
  vec_t      tab[NV];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [NL-1:0] m_shadow;
  logic m_vprev;
  int m_level, m_state, m_div;

  function automatic logic [NL*PW-1:0] put2(input int ka, input logic [PW-1:0] va,
                                            input int kb, input logic [PW-1:0] vb);
    logic [NL*PW-1:0] r;
    r = '0;
    r[ka*PW +: PW] = va;
    r[kb*PW +: PW] = vb;
    return r;
  endfunction

  function automatic logic [PW-1:0] scale_model(input logic [PW-1:0] p, input int lvl);
    int r, g, b;
    r = (int'(p[11:8]) * lvl) / 16;
    g = (int'(p[7:4]) * lvl) / 16;
    b = (int'(p[3:0]) * lvl) / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sel_model(input logic [NL*PW-1:0] l, input logic [NL-1:0] e,
                           output logic [PW-1:0] p, output logic [IW-1:0] i);
    bit found;
    found = 1'b0;
    p = BG;
    i = IW'(NL);
    for (int k = 0; k < NL; k++) begin
      if (!found && e[k] && (l[k*PW +: PW] != '0)) begin
        p = l[k*PW +: PW];
        i = IW'(k);
        found = 1'b1;
      end
    end
  endtask

  task automatic fade_model(input logic tick, input logic [1:0] c);
    bit acc_in, acc_out;
    acc_in  = (c == 2'b01) && (m_state == S_OFF || m_state == S_FOUT);
    acc_out = (c == 2'b10) && (m_state == S_ON  || m_state == S_FIN);
    if (acc_in) begin
      m_state = S_FIN;
      m_div = 0;
    end else if (acc_out) begin
      m_state = S_FOUT;
      m_div = 0;
    end else if (tick && (m_state == S_FIN || m_state == S_FOUT)) begin
      m_div++;
      if (m_div == FF) begin
        m_div = 0;
        m_level += (m_state == S_FIN) ? 1 : -1;
        if (m_level == 16) m_state = S_ON;
        else if (m_level == 0) m_state = S_OFF;
      end
    end
  endtask

  task automatic model_reset();
    m_shadow = '1;
    m_vprev  = 1'b0;
    m_level  = 16;
    m_state  = S_ON;
    m_div    = 0;
    blank_hist.delete();
    for (int k = 0; k < LAT; k++) blank_hist.push_back(1'b0);
    pix_q.delete();
    sync_q.delete();
    cyc = 0;
  endtask

  // One clock of stimulus: the model predicts, the queues hold predictions until due.
  task automatic apply_stimulus(input bit use_tab = 1'b0, input logic [PW-1:0] tp = '0,
                                input logic [IW-1:0] ti = '0);
    logic tick, old_bl;
    logic [PW-1:0] sp;
    logic [IW-1:0] si;
    pix_exp_t pe;
    sync_exp_t se;
    hsync = 1'($urandom_range(0, 1));
    tick = m_vprev && !vsync;
    sel_model(layers, m_shadow, sp, si);
    if (tick) m_shadow = en;
    fade_model(tick, cmd);
    m_vprev = vsync;
    old_bl = blank_hist.pop_front();
    blank_hist.push_back(blank);
    pe.due = cyc + 1;
    pe.pix = use_tab ? tp : (old_bl ? '0 : scale_model(sp, m_level));
    pe.idx = use_tab ? ti : si;
    pix_q.push_back(pe);
    se.due = cyc + LAT + 1;
    se.h = hsync;
    se.v = vsync;
    se.b = blank;
    sync_q.push_back(se);
    @(posedge clk);
    #1;
    while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      pe = pix_q.pop_front();
      check_output("pixel_out", 32'(pix), 32'(pe.pix));
      check_output("top_layer_out", 32'(top), 32'(pe.idx));
    end
    while (sync_q.size() > 0 && sync_q[0].due == cyc) begin
      se = sync_q.pop_front();
      check_output("sync_out", {29'b0, hs_o, vs_o, bl_o}, {29'b0, se.h, se.v, se.b});
    end
    check_output("fade_busy_out", 32'(busy), 32'(m_state == S_FIN || m_state == S_FOUT));
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic frame_tick(input logic [1:0] c);
    vsync = 1'b1;
    cmd = 2'b00;
    apply_stimulus();
    vsync = 1'b0;
    cmd = c;
    apply_stimulus();
    cmd = 2'b00;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach summary, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tab[0] = '{put2(2, 12'h0F0, 5, 12'hF00), 12'h0F0, 4'd2};
    tab[1] = '{'0,                           12'h123, 4'd8};
    tab[2] = '{put2(7, 12'h00F, 7, 12'h00F), 12'h00F, 4'd7};
    tab[3] = '{put2(0, 12'hABC, 1, 12'h111), 12'hABC, 4'd0};
    tab[4] = '{put2(3, 12'h001, 6, 12'h800), 12'h001, 4'd3};
    tab[5] = '{put2(5, 12'hF00, 5, 12'hF00), 12'hF00, 4'd5};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset pixel_out", 32'(pix), 32'h0);
    check_output("reset top_layer_out", 32'(top), 32'(NL));
    check_output("reset fade_busy_out", 32'(busy), 32'h0);
    check_output("reset sync_out", {29'b0, hs_o, vs_o, bl_o}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      layers = tab[i].layers;
      apply_stimulus(1'b1, tab[i].pix, tab[i].idx);
      apply_stimulus(1'b1, tab[i].pix, tab[i].idx);
    end

    // Enable change mid-frame stays hidden until the next vsync falling edge.
    layers = put2(2, 12'h0F0, 5, 12'hF00);
    idle(2);
    en = 8'hFB;
    idle(4);
    check_output("hidden enable pixel", 32'(pix), 32'h0F0);
    check_output("hidden enable index", 32'(top), 32'd2);
    frame_tick(2'b00);
    idle(2);
    check_output("shadow update pixel", 32'(pix), 32'hF00);
    check_output("shadow update index", 32'(top), 32'd5);
    en = '1;
    frame_tick(2'b00);
    idle(2);

    blank = 1'b1;
    idle(LAT + 3);
    check_output("blank pixel", 32'(pix), 32'h0);
    check_output("blank index", 32'(top), 32'd2);
    check_output("blank_out", 32'(bl_o), 32'h1);
    blank = 1'b0;
    idle(LAT + 3);

    layers = put2(0, 12'hFFF, 0, 12'hFFF);
    idle(2);
    cmd = 2'b10;
    apply_stimulus();
    cmd = 2'b00;
    repeat (16) frame_tick(2'b00);
    idle(2);
    check_output("fade-out level 8 pixel", 32'(pix), 32'h777);
    check_output("fade-out busy", 32'(busy), 32'h1);
    repeat (16) frame_tick(2'b00);
    idle(2);
    check_output("fade-out end pixel", 32'(pix), 32'h0);
    check_output("fade-out end busy", 32'(busy), 32'h0);

    // Command landing on a tick must not count that tick as a step.
    frame_tick(2'b01);
    repeat (31) frame_tick(2'b00);
    idle(2);
    check_output("coincident skip busy", 32'(busy), 32'h1);
    check_output("coincident skip pixel", 32'(pix), 32'hEEE);
    frame_tick(2'b00);
    idle(2);
    check_output("fade-in end busy", 32'(busy), 32'h0);
    check_output("fade-in end pixel", 32'(pix), 32'hFFF);

    cmd = 2'b10;
    apply_stimulus();
    cmd = 2'b00;
    repeat (22) frame_tick(2'b00);
    idle(2);
    check_output("level 5 pixel", 32'(pix), 32'h444);
    cmd = 2'b01;
    apply_stimulus();
    cmd = 2'b00;
    frame_tick(2'b00);
    idle(2);
    check_output("reverse first tick pixel", 32'(pix), 32'h444);
    check_output("reverse busy", 32'(busy), 32'h1);
    frame_tick(2'b00);
    idle(2);
    check_output("reverse level 6 pixel", 32'(pix), 32'h555);

    #3;
    rst_n = 1'b0;
    #1;
    check_output("async reset pixel_out", 32'(pix), 32'h0);
    check_output("async reset top_layer_out", 32'(top), 32'(NL));
    check_output("async reset fade_busy_out", 32'(busy), 32'h0);
    check_output("async reset sync_out", {29'b0, hs_o, vs_o, bl_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(3);
    check_output("post-reset level 16 pixel", 32'(pix), 32'hFFF);
    check_output("post-reset busy", 32'(busy), 32'h0);
    check_output("post-reset index", 32'(top), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
